adc_scan_scheduler: RTL and testbench

- Sequences periodic multi-channel scans of the 8-channel serial ADC. Sits between the register/Avalon side and a single-conversion SPI engine.
- Per scan tick, walks the enabled channels in ascending order and requests 2^AVG_LOG2 conversions per channel.
- Averages each channel's conversions and emits one result per channel on a valid/ready stream.
- Flags overruns and engine timeouts.

---
 rtl/adc_scan_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_adc_scan_scheduler.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_scheduler.sv
// Periodic multi-channel ADC scan sequencer with per-channel averaging,
// engine timeout and overrun detection.
module adc_scan_scheduler #(
  parameter int PERIOD_W = 16,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic                iCLK,
  input  logic                iRST_n,
  input  logic                iEN,
  input  logic [7:0]          iCH_MASK,
  input  logic [PERIOD_W-1:0] iPERIOD,
  output logic                oCONV_REQ,
  output logic [2:0]          oCONV_CH,
  input  logic                iCONV_DONE,
  input  logic [11:0]         iCONV_DATA,
  output logic                oRES_VALID,
  input  logic                iRES_READY,
  output logic [2:0]          oRES_CH,
  output logic [11:0]         oRES_DATA,
  output logic                oSCAN_DONE,
  output logic                oOVERRUN,
  output logic                oTIMEOUT,
  output logic                oBUSY
);

  localparam int AW = 12 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] NSAMP = CW'(1 << AVG_LOG2);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_REQ,
    S_ACC,
    S_OUT
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [PERIOD_W-1:0] r_per;
  logic [PERIOD_W-1:0] w_term;
  logic                w_tick;
  logic [7:0]          r_mask;
  logic [7:0]          r_pend;
  logic [2:0]          r_ch;
  logic [2:0]          w_sel_ch;
  logic                w_sel_any;
  logic [AW-1:0]       r_acc;
  logic [AW-1:0]       w_avg;
  logic [CW-1:0]       r_cnt;
  logic [TW-1:0]       r_tmo;
  logic                w_tmo_hit;
  logic                r_done;
  logic                r_ovr;
  logic                r_tmof;

  // A period of 0 behaves as 1; >= lets a shrunk period wrap at once
  assign w_term = (iPERIOD == '0) ? '0
                : iPERIOD - PERIOD_W'(1);
  assign w_tick = iEN && (r_per >= w_term);

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_per <= '0;
    end else if (!iEN || w_tick) begin
      r_per <= '0;
    end else begin
      r_per <= r_per + PERIOD_W'(1);
    end
  end

  always_comb begin
    w_sel_ch  = '0;
    w_sel_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_sel_ch  = 3'(i);
        w_sel_any = 1'b1;
      end
    end
  end

  // Done on the last allowed cycle wins over the timeout
  assign w_tmo_hit = (r_tmo == TLAST) && !iCONV_DONE;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (!iEN) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_tick) w_next = S_SEL;
        S_SEL:  w_next = w_sel_any ? S_REQ : S_IDLE;
        S_REQ: begin
          if (iCONV_DONE)     w_next = S_ACC;
          else if (w_tmo_hit) w_next = S_SEL;
        end
        S_ACC:  w_next = (r_cnt == NSAMP) ? S_OUT : S_REQ;
        S_OUT:  if (iRES_READY) w_next = S_SEL;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_mask <= '0;
      r_pend <= '0;
      r_ch   <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_tmo  <= '0;
      r_done <= 1'b0;
      r_ovr  <= 1'b0;
      r_tmof <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!iEN) begin
        r_ovr  <= 1'b0;
        r_tmof <= 1'b0;
      end else begin
        if (w_tick && r_state != S_IDLE) r_ovr <= 1'b1;
        case (r_state)
          S_IDLE: begin
            if (w_tick) begin
              r_mask <= iCH_MASK;
              r_pend <= iCH_MASK;
            end
          end
          S_SEL: begin
            r_acc <= '0;
            r_cnt <= '0;
            r_tmo <= '0;
            if (w_sel_any) begin
              r_ch             <= w_sel_ch;
              r_pend[w_sel_ch] <= 1'b0;
            end else begin
              r_done <= (r_mask != 8'h00);
            end
          end
          S_REQ: begin
            if (iCONV_DONE) begin
              r_acc <= r_acc + AW'(iCONV_DATA);
              r_cnt <= r_cnt + CW'(1);
            end else if (w_tmo_hit) begin
              r_tmof <= 1'b1;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
          S_ACC: r_tmo <= '0;
          default: ;
        endcase
      end
    end
  end

  assign w_avg      = r_acc >> AVG_LOG2;
  assign oCONV_REQ  = (r_state == S_REQ);
  assign oCONV_CH   = oCONV_REQ ? r_ch : 3'd0;
  assign oRES_VALID = (r_state == S_OUT);
  assign oRES_CH    = oRES_VALID ? r_ch : 3'd0;
  assign oRES_DATA  = oRES_VALID ? w_avg[11:0] : 12'd0;
  assign oSCAN_DONE = r_done;
  assign oOVERRUN   = r_ovr;
  assign oTIMEOUT   = r_tmof;
  assign oBUSY      = (r_state != S_IDLE);

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler with a behavioural
// SPI-engine model and a negedge result/request monitor.
module tb_adc_scan_scheduler;

  logic        iCLK = 1'b0;
  logic        iRST_n = 1'b1;
  logic        iEN = 1'b0;
  logic [7:0]  iCH_MASK = 8'h00;
  logic [15:0] iPERIOD = 16'd0;
  logic        oCONV_REQ;
  logic [2:0]  oCONV_CH;
  logic        iCONV_DONE = 1'b0;
  logic [11:0] iCONV_DATA = 12'd0;
  logic        oRES_VALID;
  logic        iRES_READY = 1'b1;
  logic [2:0]  oRES_CH;
  logic [11:0] oRES_DATA;
  logic        oSCAN_DONE;
  logic        oOVERRUN;
  logic        oTIMEOUT;
  logic        oBUSY;

  adc_scan_scheduler dut (
    .iCLK       (iCLK),
    .iRST_n     (iRST_n),
    .iEN        (iEN),
    .iCH_MASK   (iCH_MASK),
    .iPERIOD    (iPERIOD),
    .oCONV_REQ  (oCONV_REQ),
    .oCONV_CH   (oCONV_CH),
    .iCONV_DONE (iCONV_DONE),
    .iCONV_DATA (iCONV_DATA),
    .oRES_VALID (oRES_VALID),
    .iRES_READY (iRES_READY),
    .oRES_CH    (oRES_CH),
    .oRES_DATA  (oRES_DATA),
    .oSCAN_DONE (oSCAN_DONE),
    .oOVERRUN   (oOVERRUN),
    .oTIMEOUT   (oTIMEOUT),
    .oBUSY      (oBUSY)
  );

  always #5 iCLK = ~iCLK;

  logic [23:0] outs;
  assign outs = {oCONV_REQ, oCONV_CH, oRES_VALID,
                 oRES_CH, oRES_DATA, oSCAN_DONE,
                 oOVERRUN, oTIMEOUT, oBUSY};

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  // Engine model
  logic [11:0] eng_data [8][4];
  int          eng_lat  [8];
  bit          eng_hang [8];
  logic [1:0]  eng_idx  [8];

  initial begin
    logic [2:0] ech;
    int         k;
    forever begin
      @(posedge iCLK);
      #1;
      if (oCONV_REQ) begin
        ech = oCONV_CH;
        if (eng_hang[ech]) begin
          k = 0;
          while (oCONV_REQ && k < 1000) begin
            @(posedge iCLK);
            #1;
            k++;
          end
        end else begin
          repeat (eng_lat[ech]) begin
            @(posedge iCLK);
            #1;
          end
          iCONV_DONE = 1'b1;
          iCONV_DATA = eng_data[ech][eng_idx[ech]];
          eng_idx[ech] = eng_idx[ech] + 2'd1;
          @(posedge iCLK);
          #1;
          iCONV_DONE = 1'b0;
        end
      end
    end
  end

  // Monitor
  int          n_rise = 0;
  int          n_done = 0;
  int          cur_len = 0;
  int          last_len = 0;
  logic        prev_req = 1'b0;
  logic [2:0]  q_conv[$];
  logic [14:0] q_res[$];

  initial begin
    forever begin
      @(negedge iCLK);
      if (oCONV_REQ && !prev_req) begin
        n_rise++;
        q_conv.push_back(oCONV_CH);
      end
      if (oCONV_REQ) begin
        cur_len++;
      end else begin
        if (prev_req) last_len = cur_len;
        cur_len = 0;
      end
      if (oRES_VALID && iRES_READY)
        q_res.push_back({oRES_CH, oRES_DATA});
      if (oSCAN_DONE) n_done++;
      prev_req = oCONV_REQ;
    end
  end

  task automatic idle_all();
    iEN = 1'b0;
    step(80);
    q_conv.delete();
    q_res.delete();
    for (int i = 0; i < 8; i++) begin
      eng_idx[i]  = 2'd0;
      eng_lat[i]  = 3;
      eng_hang[i] = 1'b0;
    end
  endtask

  task automatic wait_done(input int base,
                           input int lim,
                           input string tag);
    int k = 0;
    while (n_done <= base && k < lim) begin
      step(1);
      k++;
    end
    check(tag, 32'(k < lim), 32'd1);
  endtask

  task automatic wait_req(input int lim,
                          input string tag);
    int k = 0;
    while (!oCONV_REQ && k < lim) begin
      step(1);
      k++;
    end
    check(tag, 32'(k < lim), 32'd1);
  endtask

  task automatic wait_valid(input int lim,
                            input string tag);
    int k = 0;
    while (!oRES_VALID && k < lim) begin
      step(1);
      k++;
    end
    check(tag, 32'(k < lim), 32'd1);
  endtask

  initial begin
    int          base;
    int          r0;
    logic [23:0] seq;
    logic [2:0]  cap_ch;
    logic [11:0] cap_d;
    bit          stable;

    for (int c = 0; c < 8; c++) begin
      eng_lat[c]  = 3;
      eng_hang[c] = 1'b0;
      eng_idx[c]  = 2'd0;
      for (int k = 0; k < 4; k++)
        eng_data[c][k] = 12'd0;
    end

    #2 iRST_n = 1'b0;
    #2 check("reset_outs", 32'(outs), 32'd0);
    @(posedge iCLK);
    #1 iRST_n = 1'b1;
    step(2);

    // Basic scan
    for (int k = 0; k < 4; k++) begin
      eng_data[0][k] = 12'(100 + k);
      eng_data[2][k] = 12'd4000;
    end
    iPERIOD = 16'd1000;
    iCH_MASK = 8'h05;
    iRES_READY = 1'b1;
    base = n_done;
    iEN = 1'b1;
    step(990);
    check("t1_no_tick", 32'(n_done - base), 32'd0);
    step(110);
    check("t1_done1", 32'(n_done - base), 32'd1);
    check("t1_nres", 32'(q_res.size()), 32'd2);
    check("t1_res0", 32'(q_res[0]), {17'd0, 3'd0, 12'd101});
    check("t1_res1", 32'(q_res[1]), {17'd0, 3'd2, 12'd4000});
    seq = '0;
    for (int i = 0; i < 8; i++)
      seq = {seq[20:0],
             (i < q_conv.size()) ? q_conv[i] : 3'd7};
    check("t1_conv_seq", 32'(seq), 32'h000492);
    step(1000);
    check("t1_done2", 32'(n_done - base), 32'd2);
    check("t1_flags", {30'd0, oOVERRUN, oTIMEOUT}, 32'd0);
    idle_all();

    // Backpressure
    eng_data[1][0] = 12'd10;
    eng_data[1][1] = 12'd20;
    eng_data[1][2] = 12'd30;
    eng_data[1][3] = 12'd41;
    iPERIOD = 16'd200;
    iCH_MASK = 8'h02;
    iRES_READY = 1'b0;
    iEN = 1'b1;
    wait_valid(400, "t2_valid_seen");
    check("t2_ch", 32'(oRES_CH), 32'd1);
    check("t2_data", 32'(oRES_DATA), 32'd25);
    cap_ch = oRES_CH;
    cap_d = oRES_DATA;
    r0 = n_rise;
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (!oRES_VALID || oRES_CH !== cap_ch ||
          oRES_DATA !== cap_d)
        stable = 1'b0;
    end
    check("t2_stable", 32'(stable), 32'd1);
    check("t2_no_req", 32'(n_rise - r0), 32'd0);
    iRES_READY = 1'b1;
    step(1);
    check("t2_valid_drop", 32'(oRES_VALID), 32'd0);
    step(1);
    check("t2_scan_done", 32'(oSCAN_DONE), 32'd1);
    step(1);
    check("t2_done_pulse", 32'(oSCAN_DONE), 32'd0);
    check("t2_nres", 32'(q_res.size()), 32'd1);
    idle_all();

    // Overrun, ch0..ch7 order
    for (int c = 0; c < 8; c++)
      for (int k = 0; k < 4; k++)
        eng_data[c][k] = 12'(c * 100 + k * 2);
    iPERIOD = 16'd5;
    iCH_MASK = 8'hFF;
    iRES_READY = 1'b1;
    base = n_done;
    iEN = 1'b1;
    step(12);
    check("t3_overrun", 32'(oOVERRUN), 32'd1);
    wait_done(base, 1500, "t3_scan_done");
    check("t3_nres", 32'(q_res.size() >= 8), 32'd1);
    for (int c = 0; c < 8; c++)
      check("t3_res", 32'(q_res[c]),
            {17'd0, 3'(c), 12'(c * 100 + 3)});
    idle_all();

    // Timeout: ch1 never answers
    for (int k = 0; k < 4; k++) begin
      eng_data[0][k] = 12'd100;
      eng_data[1][k] = 12'd200;
    end
    eng_hang[1] = 1'b1;
    iPERIOD = 16'd300;
    iCH_MASK = 8'h03;
    base = n_done;
    iEN = 1'b1;
    wait_done(base, 1000, "t4_scan_done");
    check("t4_timeout", 32'(oTIMEOUT), 32'd1);
    check("t4_nres", 32'(q_res.size()), 32'd1);
    check("t4_res0", 32'(q_res[0]), {17'd0, 3'd0, 12'd100});
    check("t4_req_len", 32'(last_len), 32'd64);
    idle_all();

    // Done on the exact expiry cycle
    eng_lat[1] = 63;
    iPERIOD = 16'd600;
    base = n_done;
    iEN = 1'b1;
    wait_done(base, 1500, "t4b_scan_done");
    check("t4b_timeout", 32'(oTIMEOUT), 32'd0);
    check("t4b_nres", 32'(q_res.size()), 32'd2);
    check("t4b_res1", 32'(q_res[1]), {17'd0, 3'd1, 12'd200});
    idle_all();

    // Done one cycle late
    eng_lat[1] = 64;
    base = n_done;
    iEN = 1'b1;
    wait_done(base, 1500, "t4c_scan_done");
    check("t4c_timeout", 32'(oTIMEOUT), 32'd1);
    check("t4c_nres", 32'(q_res.size()), 32'd1);
    iEN = 1'b0;
    step(1);
    check("t4c_sticky_clr", 32'(oTIMEOUT), 32'd0);
    idle_all();

    // Period 0 and abort during REQ
    eng_lat[0] = 10;
    iPERIOD = 16'd0;
    iCH_MASK = 8'h01;
    iRES_READY = 1'b1;
    iEN = 1'b1;
    wait_req(50, "t5_req_seen");
    check("t5_ovr_p0", 32'(oOVERRUN), 32'd1);
    iEN = 1'b0;
    step(1);
    check("t5_abort_req",
          {26'd0, oCONV_REQ, oRES_VALID, oBUSY,
           oSCAN_DONE, oOVERRUN, oTIMEOUT}, 32'd0);
    idle_all();

    // Abort during OUTPUT
    iPERIOD = 16'd20;
    iRES_READY = 1'b0;
    iEN = 1'b1;
    wait_valid(200, "t6_valid_seen");
    iEN = 1'b0;
    step(1);
    check("t6_abort_out",
          {29'd0, oRES_VALID, oBUSY, oCONV_REQ}, 32'd0);
    idle_all();

    // Asynchronous reset mid-scan
    iPERIOD = 16'd20;
    iRES_READY = 1'b0;
    iEN = 1'b1;
    wait_valid(200, "t7_valid_seen");
    check("t7_data", 32'(oRES_DATA), 32'd100);
    iPERIOD = 16'd0;
    step(2);
    check("t7_ovr", 32'(oOVERRUN), 32'd1);
    #1 iRST_n = 1'b0;
    #1 check("t7_async_rst", 32'(outs), 32'd0);
    iEN = 1'b0;
    step(2);
    iRST_n = 1'b1;
    iRES_READY = 1'b1;
    idle_all();

    // Empty mask
    iPERIOD = 16'd10;
    iCH_MASK = 8'h00;
    r0 = n_rise;
    base = n_done;
    iEN = 1'b1;
    step(60);
    check("t8_no_req", 32'(n_rise - r0), 32'd0);
    check("t8_no_done", 32'(n_done - base), 32'd0);
    iEN = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
